// File: rtl/stage_ex_mulpipe.sv
`default_nettype none
// ============================================================================
//  Module      : stage_ex_mulpipe
//  Description : Execute stage of the in-order multithreaded core. A
//                single-cycle ALU and a MUL_STAGES-deep multiplier share one
//                registered output slot. Program order is kept: multiplies
//                stream back to back, and a non-multiply waits until the
//                multiplier has drained.
//  Option      : `define MULH_EN adds the high product half (signed or
//                unsigned, selected per op by in_mul_hi / in_mul_signed).
//  Ports       : clk, rst (async, active high), flush (sync kill)
//                in_valid/in_ready  - op handshake from ID/EX
//                in_thread, in_dst, in_pc, in_r1, in_r2, in_imm, in_sel_a,
//                in_sel_b, in_alu_func, in_is_mul, in_mul_hi, in_mul_signed,
//                in_flag_reg        - op fields
//                out_valid/out_ready - result handshake to TL/MEM
//                out_thread, out_dst, out_pc, out_data, out_is_equal,
//                out_is_mul, out_flag_reg - result fields
//                busy               - any multiplier stage occupied
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_ex_mulpipe #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 4,
    parameter int TAG_W      = 5,
    parameter int THREAD_W   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [THREAD_W-1:0] in_thread,
    input  logic [TAG_W-1:0]    in_dst,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_r1,
    input  logic [XLEN-1:0]     in_r2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic                in_sel_a,
    input  logic                in_sel_b,
    input  logic [3:0]          in_alu_func,
    input  logic                in_is_mul,
    input  logic                in_mul_hi,
    input  logic                in_mul_signed,
    input  logic                in_flag_reg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [THREAD_W-1:0] out_thread,
    output logic [TAG_W-1:0]    out_dst,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_data,
    output logic                out_is_equal,
    output logic                out_is_mul,
    output logic                out_flag_reg,
    output logic                busy
);

    localparam int c_SH_W       = $clog2(XLEN);
    // The output slot is the last multiplier stage, so only MUL_STAGES-1
    // internal stages are needed to reach the specified latency.
    localparam int c_NPIPE      = MUL_STAGES - 1;
    localparam bit c_DIRECT_MUL = (MUL_STAGES == 1);
`ifdef MULH_EN
    localparam int c_PW = 2 * XLEN;
`else
    localparam int c_PW = XLEN;
`endif

    typedef struct packed {
        logic [THREAD_W-1:0] thread;
        logic [TAG_W-1:0]    dst;
        logic [XLEN-1:0]     pc;
        logic [c_PW-1:0]     prod;
        logic                is_equal;
        logic                flag_reg;
`ifdef MULH_EN
        logic                hi;
`endif
    } mul_op_t;

    typedef struct packed {
        logic                valid;
        logic [THREAD_W-1:0] thread;
        logic [TAG_W-1:0]    dst;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     data;
        logic                is_equal;
        logic                is_mul;
        logic                flag_reg;
    } slot_t;

    slot_t           slot_q, slot_d;
    logic            w_advance, w_accept, w_is_equal, w_busy, w_last_v;
    mul_op_t         w_last;
    logic [XLEN-1:0] w_last_res, w_in_mul_res, w_alu_res;
    logic [XLEN-1:0] w_op_a, w_op_b;
    logic [c_SH_W-1:0] w_shamt;
    logic [c_PW-1:0] w_prod;

    // ---------------- handshake ----------------
    assign w_advance  = !slot_q.valid | out_ready;
    assign in_ready   = w_advance & !flush & (in_is_mul | !w_busy);
    assign w_accept   = in_valid & in_ready;
    assign w_is_equal = (in_r1 == in_r2);
    assign busy       = w_busy;

    // ---------------- multiplier front end ----------------
`ifdef MULH_EN
    logic w_ext_a, w_ext_b;
    assign w_ext_a = in_mul_signed & in_r1[XLEN-1];
    assign w_ext_b = in_mul_signed & in_r2[XLEN-1];
    // Sign- or zero-extending to 2*XLEN lets one multiply serve both the
    // signed and the unsigned high half; the low half is identical for both.
    assign w_prod       = {{XLEN{w_ext_a}}, in_r1} * {{XLEN{w_ext_b}}, in_r2};
    assign w_in_mul_res = in_mul_hi ? w_prod[c_PW-1:XLEN] : w_prod[XLEN-1:0];
`else
    logic w_unused_mulh;
    assign w_unused_mulh = in_mul_hi ^ in_mul_signed;
    assign w_prod        = in_r1 * in_r2;
    assign w_in_mul_res  = w_prod;
`endif

    // ---------------- multiplier stages ----------------
    if (c_NPIPE > 0) begin : g_pipe
        mul_op_t            stg_q [c_NPIPE];
        logic [c_NPIPE-1:0] stg_v_q;
        mul_op_t            w_mul_in;

        always_comb begin
            w_mul_in          = '0;
            w_mul_in.thread   = in_thread;
            w_mul_in.dst      = in_dst;
            w_mul_in.pc       = in_pc;
            w_mul_in.prod     = w_prod;
            w_mul_in.is_equal = w_is_equal;
            w_mul_in.flag_reg = in_flag_reg;
`ifdef MULH_EN
            w_mul_in.hi       = in_mul_hi;
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stg_v_q <= '0;
                for (int k = 0; k < c_NPIPE; k++) stg_q[k] <= '0;
            end else begin
                if (flush) begin
                    stg_v_q <= '0;
                end else if (w_advance) begin
                    stg_v_q[0] <= w_accept & in_is_mul;
                    for (int k = 1; k < c_NPIPE; k++) stg_v_q[k] <= stg_v_q[k-1];
                end
                // Data may go stale on flush; only the valid bits matter.
                if (w_advance) begin
                    stg_q[0] <= w_mul_in;
                    for (int k = 1; k < c_NPIPE; k++) stg_q[k] <= stg_q[k-1];
                end
            end
        end

        assign w_last   = stg_q[c_NPIPE-1];
        assign w_last_v = stg_v_q[c_NPIPE-1];
        assign w_busy   = |stg_v_q;
`ifdef MULH_EN
        assign w_last_res = w_last.hi ? w_last.prod[c_PW-1:XLEN] : w_last.prod[XLEN-1:0];
`else
        assign w_last_res = w_last.prod;
`endif
    end else begin : g_direct
        assign w_last     = '0;
        assign w_last_v   = 1'b0;
        assign w_busy     = 1'b0;
        assign w_last_res = '0;
    end

    // ---------------- ALU ----------------
    assign w_op_a  = in_sel_a ? in_pc  : in_r1;
    assign w_op_b  = in_sel_b ? in_imm : in_r2;
    assign w_shamt = w_op_b[c_SH_W-1:0];

    always_comb begin
        w_alu_res = '0;
        case (in_alu_func)
            4'd0:    w_alu_res = w_op_a + w_op_b;
            4'd1:    w_alu_res = w_op_a - w_op_b;
            4'd2:    w_alu_res = w_op_a & w_op_b;
            4'd3:    w_alu_res = w_op_a | w_op_b;
            4'd4:    w_alu_res = w_op_a ^ w_op_b;
            4'd5:    w_alu_res = w_op_a << w_shamt;
            4'd6:    w_alu_res = w_op_a >> w_shamt;
            4'd7:    w_alu_res = $unsigned($signed(w_op_a) >>> w_shamt);
            4'd8:    w_alu_res = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            4'd9:    w_alu_res = {{(XLEN-1){1'b0}}, (w_op_a < w_op_b)};
            4'd10:   w_alu_res = w_op_b;
            default: w_alu_res = '0;
        endcase
    end

    // ---------------- output slot ----------------
    always_comb begin
        slot_d = slot_q;
        if (flush) begin
            slot_d.valid = 1'b0;
        end else if (w_advance) begin
            if (w_last_v) begin
                slot_d.valid    = 1'b1;
                slot_d.thread   = w_last.thread;
                slot_d.dst      = w_last.dst;
                slot_d.pc       = w_last.pc;
                slot_d.data     = w_last_res;
                slot_d.is_equal = w_last.is_equal;
                slot_d.is_mul   = 1'b1;
                slot_d.flag_reg = w_last.flag_reg;
            end else if (w_accept && (!in_is_mul || c_DIRECT_MUL)) begin
                // A single-stage multiply skips the pipe and lands here
                // exactly like an ALU op.
                slot_d.valid    = 1'b1;
                slot_d.thread   = in_thread;
                slot_d.dst      = in_dst;
                slot_d.pc       = in_pc;
                slot_d.data     = in_is_mul ? w_in_mul_res : w_alu_res;
                slot_d.is_equal = w_is_equal;
                slot_d.is_mul   = in_is_mul;
                slot_d.flag_reg = in_flag_reg;
            end else begin
                slot_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end

    assign out_valid    = slot_q.valid;
    assign out_thread   = slot_q.thread;
    assign out_dst      = slot_q.dst;
    assign out_pc       = slot_q.pc;
    assign out_data     = slot_q.data;
    assign out_is_equal = slot_q.is_equal;
    assign out_is_mul   = slot_q.is_mul;
    assign out_flag_reg = slot_q.flag_reg;

endmodule
`default_nettype wire

// File: tb/tb_stage_ex_mulpipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_ex_mulpipe
//  Description : Self-checking bench for stage_ex_mulpipe. A behavioural
//                model predicts each accepted op's result into a queue; a
//                monitor compares every consumed output against it. Directed
//                sequences cover latency, ordering, backpressure, flush and
//                reset; a randomized phase mixes ops with random backpressure.
//  Option      : MULH_EN enables the high-half multiply sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_ex_mulpipe;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_thread = '0;
    logic [4:0]  in_dst = '0;
    logic [31:0] in_pc = '0, in_r1 = '0, in_r2 = '0, in_imm = '0;
    logic        in_sel_a = 1'b0, in_sel_b = 1'b0;
    logic [3:0]  in_alu_func = '0;
    logic        in_is_mul = 1'b0, in_mul_hi = 1'b0, in_mul_signed = 1'b0, in_flag_reg = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [1:0]  out_thread;
    logic [4:0]  out_dst;
    logic [31:0] out_pc, out_data;
    logic        out_is_equal, out_is_mul, out_flag_reg, busy;

    stage_ex_mulpipe #(.XLEN(32), .MUL_STAGES(4), .TAG_W(5), .THREAD_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_thread(in_thread), .in_dst(in_dst),
        .in_pc(in_pc), .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm),
        .in_sel_a(in_sel_a), .in_sel_b(in_sel_b), .in_alu_func(in_alu_func),
        .in_is_mul(in_is_mul), .in_mul_hi(in_mul_hi), .in_mul_signed(in_mul_signed),
        .in_flag_reg(in_flag_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_thread(out_thread),
        .out_dst(out_dst), .out_pc(out_pc), .out_data(out_data),
        .out_is_equal(out_is_equal), .out_is_mul(out_is_mul), .out_flag_reg(out_flag_reg),
        .busy(busy)
    );

    typedef struct packed {
        logic [1:0]  thread;
        logic [4:0]  dst;
        logic [31:0] pc, r1, r2, imm;
        logic        sel_a, sel_b;
        logic [3:0]  func;
        logic        is_mul, hi, sgn, flag;
    } op_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dst;
        logic [1:0]  thread;
        logic [31:0] pc;
        logic        eq, is_mul, flag;
    } exp_t;

    typedef struct { int c; logic [31:0] d; } log_t;

    exp_t exp_q[$];
    log_t log_q[$];
    exp_t mon_got, mon_exp;
    int   n_checks = 0, n_pass = 0, cyc = 0;
    bit   rand_bp = 1'b0;
    logic ready_dir = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_dir;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Reference model: results straight from the instruction semantics.
    function automatic exp_t model(input op_t o);
        logic [31:0] a, b, r;
        logic [4:0]  sh;
        logic [63:0] p;
`ifdef MULH_EN
        longint sa, sb;
`endif
        exp_t e;
        a  = o.sel_a ? o.pc : o.r1;
        b  = o.sel_b ? o.imm : o.r2;
        sh = b[4:0];
        r  = '0;
        if (o.is_mul) begin
            p = {32'h0, o.r1} * {32'h0, o.r2};
            r = p[31:0];
`ifdef MULH_EN
            if (o.hi) begin
                if (o.sgn) begin
                    sa = $signed(o.r1);
                    sb = $signed(o.r2);
                    p  = sa * sb;
                end
                r = p[63:32];
            end
`endif
        end else begin
            case (o.func)
                4'd0:    r = a + b;
                4'd1:    r = a - b;
                4'd2:    r = a & b;
                4'd3:    r = a | b;
                4'd4:    r = a ^ b;
                4'd5:    r = a << sh;
                4'd6:    r = a >> sh;
                4'd7:    r = a[31] ? ~((~a) >> sh) : (a >> sh);
                4'd8:    r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                4'd9:    r = (a < b) ? 32'd1 : 32'd0;
                4'd10:   r = b;
                default: r = '0;
            endcase
        end
        e.data = r; e.dst = o.dst; e.thread = o.thread; e.pc = o.pc;
        e.eq = (o.r1 == o.r2); e.is_mul = o.is_mul; e.flag = o.flag;
        return e;
    endfunction

    function automatic op_t mk_alu(input logic [3:0] f, input logic [31:0] r1, r2, imm,
                                   input logic sa, sb);
        op_t o = '0;
        o.func = f; o.r1 = r1; o.r2 = r2; o.imm = imm; o.sel_a = sa; o.sel_b = sb;
        o.pc = $urandom; o.thread = 2'($urandom); o.dst = 5'($urandom); o.flag = 1'b1;
        return o;
    endfunction

    function automatic op_t mk_mul(input logic [31:0] r1, r2, input logic hi, sgn);
        op_t o = mk_alu(4'($urandom), r1, r2, $urandom, 1'($urandom), 1'($urandom));
        o.is_mul = 1'b1; o.hi = hi; o.sgn = sgn;
        return o;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every consumed output is compared with the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else if (out_valid && out_ready) begin
                mon_got = '{data: out_data, dst: out_dst, thread: out_thread, pc: out_pc,
                            eq: out_is_equal, is_mul: out_is_mul, flag: out_flag_reg};
                log_q.push_back('{cyc, out_data});
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: actual data=%0h with no pending op", out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", mon_got, mon_exp);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic offer(input op_t o, output int t_acc, output int stalls);
        bit done = 1'b0;
        in_valid = 1'b1; in_thread = o.thread; in_dst = o.dst; in_pc = o.pc;
        in_r1 = o.r1; in_r2 = o.r2; in_imm = o.imm; in_sel_a = o.sel_a; in_sel_b = o.sel_b;
        in_alu_func = o.func; in_is_mul = o.is_mul; in_mul_hi = o.hi; in_mul_signed = o.sgn;
        in_flag_reg = o.flag;
        stalls = 0; t_acc = -100;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(o));
                t_acc = cyc;
                done  = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL accept_timeout: in_ready=0 for 200 cycles, required 1");
        end
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        if (log_q.size() < n) begin
            n_checks++;
            $display("FAIL output_timeout: got %0d outputs, required %0d", log_q.size(), n);
        end
    endtask

    task automatic realign();
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t o;
        int  ta, tb_, tc, st, st2;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_out_data", out_data, 0);
        rst = 1'b0;
        realign();

        // ---- ALU ----
        o = mk_alu(4'd0, 32'd5, 32'd99, 32'd7, 1'b0, 1'b1);
        o.dst = 5'd3;
        log_q.delete(); offer(o, ta, st); wait_log(1);
        check("add_latency", log_q[0].c - ta, 1);
        check("add_data", log_q[0].d, 32'd12);
        check("add_dst", out_dst, 5'd3);
        realign();
        log_q.delete(); offer(mk_alu(4'd1, 32'd0, 32'd1, 32'd0, 1'b0, 1'b0), ta, st); wait_log(1);
        check("sub_data", log_q[0].d, 32'hFFFF_FFFF);
        realign();
        log_q.delete(); offer(mk_alu(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b0, 1'b1), ta, st); wait_log(1);
        check("sra_data", log_q[0].d, 32'hF800_0000);
        realign();

        // ---- back-to-back multiplies ----
        log_q.delete();
        offer(mk_mul(32'd3, 32'd4, 1'b0, 1'b0), ta, st);
        offer(mk_mul(32'd5, 32'd6, 1'b0, 1'b0), tb_, st);
        offer(mk_mul(32'd7, 32'd8, 1'b0, 1'b0), tc, st2);
        check("b2b_accept_2", tb_ - ta, 1);
        check("b2b_accept_3", tc - ta, 2);
        wait_log(3);
        check("b2b_lat_1", log_q[0].c - ta, 4);
        check("b2b_data_1", log_q[0].d, 32'd12);
        check("b2b_lat_2", log_q[1].c - ta, 5);
        check("b2b_data_2", log_q[1].d, 32'd30);
        check("b2b_lat_3", log_q[2].c - ta, 6);
        check("b2b_data_3", log_q[2].d, 32'd56);
        realign();

        // ---- ordering: ALU waits for the multiplier to drain ----
        log_q.delete();
        offer(mk_mul(32'd9, 32'd9, 1'b0, 1'b0), ta, st);
        offer(mk_alu(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0), tb_, st);
        check("order_stalls", st, 3);
        check("order_accept", tb_ - ta, 4);
        wait_log(2);
        check("order_mul_cycle", log_q[0].c - ta, 4);
        check("order_mul_data", log_q[0].d, 32'd81);
        check("order_alu_cycle", log_q[1].c - ta, 5);
        check("order_alu_data", log_q[1].d, 32'd3);
        realign();

        // ---- backpressure ----
        ready_dir = 1'b0;
        repeat (2) realign();
        log_q.delete();
        offer(mk_mul(32'd11, 32'd13, 1'b0, 1'b0), ta, st);
        offer(mk_mul(32'd17, 32'd19, 1'b0, 1'b0), tb_, st);
        repeat (5) realign();
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data_a", out_data, 32'd143);
        repeat (3) realign();
        check("bp_hold_data_b", out_data, 32'd143);
        check("bp_hold_busy", busy, 1);
        check("bp_no_consume", log_q.size(), 0);
        ready_dir = 1'b1;
        wait_log(2);
        check("bp_data_1", log_q[0].d, 32'd143);
        check("bp_data_2", log_q[1].d, 32'd323);
        realign();

        // ---- flush with three multiplies in flight ----
        log_q.delete();
        offer(mk_mul(32'd2, 32'd2, 1'b0, 1'b0), ta, st);
        offer(mk_mul(32'd3, 32'd3, 1'b0, 1'b0), ta, st);
        offer(mk_mul(32'd4, 32'd4, 1'b0, 1'b0), ta, st);
        flush = 1'b1; in_valid = 1'b1; in_is_mul = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (10) realign();
        check("flush_no_output", log_q.size(), 0);
        check("flush_busy", busy, 0);
        check("flush_out_valid", out_valid, 0);

`ifdef MULH_EN
        // ---- high product half ----
        log_q.delete();
        offer(mk_mul(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1), ta, st);
        offer(mk_mul(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0), ta, st);
        wait_log(2);
        check("mulh_signed", log_q[0].d, 32'hFFFF_FFFF);
        check("mulh_unsigned", log_q[1].d, 32'h0000_0001);
        realign();
`endif

        // ---- reset mid-stream ----
        offer(mk_mul(32'd6, 32'd7, 1'b0, 1'b0), ta, st);
        offer(mk_mul(32'd2, 32'd3, 1'b0, 1'b0), ta, st);
        ready_dir = 1'b0;
        repeat (3) realign();
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        ready_dir = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        realign();
        log_q.delete();
        offer(mk_alu(4'd4, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 1'b0, 1'b0), ta, st);
        check("post_rst_accept_stalls", st, 0);
        wait_log(1);
        check("post_rst_data", log_q[0].d, 32'hFF00_FF00);
        realign();

        // ---- randomized mix with random backpressure and flushes ----
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                flush = 1'b1;
                realign();
                flush = 1'b0;
            end else begin
                if ($urandom_range(0, 2) == 0)
                    o = mk_mul(pick(), pick(), 1'($urandom), 1'($urandom));
                else
                    o = mk_alu(4'($urandom), pick(), pick(), pick(), 1'($urandom), 1'($urandom));
                o.flag = 1'($urandom);
                offer(o, ta, st);
                if ($urandom_range(0, 3) == 0) realign();
            end
        end
        rand_bp = 1'b0;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) realign();
        check("drain_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stage_ex_mulpipe.md
Name: stage_ex_mulpipe

Overview:
- Parametrised execute stage for the in-order multithreaded core.
- Single-cycle ALU path and a MUL_STAGES-deep pipelined multiplier, both feeding one registered output slot.
- valid/ready handshakes on input (from ID/EX) and output (to TL/MEM).
- Preserves program order: back-to-back multiplies pipeline; a non-multiply waits until the multiplier drains.

Parameters:
XLEN, 32, operand/result width (power of two, >=8)
MUL_STAGES, 4, multiplier latency in cycles from accept to output slot (>=1)
TAG_W, 5, destination register index width
THREAD_W, 2, thread id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all in-flight ops
in_valid  in  1  ID/EX offers an op
in_ready  out  1  stage accepts the op this cycle
in_thread  in  THREAD_W  thread id
in_dst  in  TAG_W  destination register
in_pc  in  XLEN  instruction pc
in_r1, in_r2  in  XLEN  register operands
in_imm  in  XLEN  immediate
in_sel_a  in  1  0: op_a=r1, 1: op_a=pc
in_sel_b  in  1  0: op_b=r2, 1: op_b=imm
in_alu_func  in  4  ALU operation
in_is_mul  in  1  op uses multiplier
in_mul_hi  in  1  select high product half (MULH_EN only)
in_mul_signed  in  1  signed high product (MULH_EN only)
in_flag_reg  in  1  op writes the register file
out_valid  out  1  output slot holds a result
out_ready  in  1  downstream consumes the slot
out_thread, out_dst, out_pc  out  THREAD_W/TAG_W/XLEN  carried from accept
out_data  out  XLEN  ALU or multiply result
out_is_equal  out  1  (r1 == r2), captured at accept
out_is_mul, out_flag_reg  out  1  carried flags
busy  out  1  any multiplier stage valid

Behaviour:
- Reset (async): all stage valid bits, out_valid and every out_* register are 0; busy=0.
- advance = !out_valid | out_ready. When advance=0, the multiplier pipe and the output slot hold.
- Multiplier stages S1..S_N each hold a valid bit, a partial/final product and the carried fields.
- in_ready = advance & !flush & (in_is_mul | no Sk valid, k=1..N). This depends on in_is_mul combinationally; in_ready is meaningful only while in_valid=1.
- Accept (in_valid & in_ready):
  - mul: enters S1.
  - non-mul: ALU result loads the output slot at the next edge; latency 1.
- Mul latency: accepted at edge t, out_valid at edge t+MUL_STAGES, provided there is no backpressure. Throughput is 1 per cycle.
- On advance:
  - S_N valid: S_N moves to the output slot.
  - Otherwise: an accepted ALU op moves to the output slot.
  - Otherwise: out_valid drops to 0.
  - The two sources are never valid together, by the in_ready rule.
- ALU: op_a/op_b per the sel bits. Codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount = op_b[log2(XLEN)-1:0]
  - 8 SLT (signed), 9 SLTU
  - 10 PASS_B
  - 11-15 produce 0
- Results wrap modulo 2^XLEN.
- Multiply uses r1 and r2 only, never pc/imm. Default result is the low XLEN bits of the product.
- flush: at the next edge, clears all Sk valid bits and out_valid. Wins over an accept in the same cycle (in_ready is forced 0) and over out_ready. Data registers may keep stale values.
- rst asserted mid-operation: clears everything immediately and discards in-flight multiplies.
- MUL_STAGES=1: the multiply behaves like the ALU (latency 1), but the ordering rule still applies.

Optional Feature:
MULH_EN
- Defined:
  - in_mul_hi=1 returns product bits [2*XLEN-1:XLEN].
  - in_mul_signed selects signed×signed (1) or unsigned×unsigned (0) for that high half.
  - Both bits are carried through the stages with the op.
- Undefined:
  - in_mul_hi and in_mul_signed are ignored; the result is always the low half.
  - The product width may be truncated to XLEN bits to save area.

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> out_valid=0, busy=0, out_data=0; first op after release is accepted.
- ALU: ADD r1=5, imm=7, sel_b=1, dst=3 -> next cycle out_valid=1, out_data=12, out_dst=3. SUB 0-1 -> 0xFFFFFFFF. SRA 0x80000000 by 4 -> 0xF8000000.
- Back-to-back muls (MUL_STAGES=4), 3×4, 5×6, 7×8 accepted on cycles 0, 1, 2 -> out_data 12, 30, 56 on cycles 4, 5, 6; in_ready stays 1.
- Ordering: mul 9×9 at cycle 0, then ADD offered at cycle 1 -> in_ready=0 for cycles 1-3 and 1 in cycle 4; 81 is output at cycle 4, ADD result at cycle 5.
- Backpressure: out_ready=0 for 5 cycles with 2 muls in flight -> pipe holds, out_data stable, no loss; both results delivered in order after release.
- Flush and MULH_EN: flush while 3 muls are in flight -> no further out_valid. With MULH_EN, signed hi of 0xFFFFFFFF×2 -> 0xFFFFFFFF; unsigned hi -> 0x00000001.
